wb_writeback_unit: RTL and testbench
====================================

# wb_writeback_unit

Parametrised, clocked write-back stage for the pipelined MIPS core. It replaces the delay-driven write-enable pulse with a real MEM/WB pipeline register. It selects among four result sources, extracts and extends sub-word loads, and drives exactly one register-file write per retired instruction. It sits between the memory stage and the register-file write port, and supplies a forwarding tap to the execute-stage hazard logic.

## Interface
- DATA_W, 32, datapath width; must be 32 or 64
- ADDR_W, 5, register address width
- OFF_W, $clog2(DATA_W/8), byte-offset width
- CNT_W, 32, width of the retire counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage accepts this cycle; equals !stall || !wb_valid
- stall  in  1  register-file port busy; hold the current entry
- flush  in  1  discard the held entry and any incoming entry
- regwrite  in  1  instruction writes a register
- res_sel  in  2  result source: 00 ALU, 01 MEM, 10 LINK, 11 IMM
- alu_result, mem_data, link_pc, imm_value  in  DATA_W  result sources
- byte_off  in  OFF_W  low address bits of the load
- ld_size  in  2  load size: 00 byte, 01 half, 10 word (32 bits), 11 full DATA_W
- ld_unsigned  in  1  zero-extend instead of sign-extend
- dest_addr  in  ADDR_W  destination register
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- fwd_valid  out  1  held entry will write a non-zero register
- fwd_addr  out  ADDR_W  forwarding address
- fwd_data  out  DATA_W  forwarding data
- err_misalign  out  1  the retiring load is misaligned
- retire_cnt  out  CNT_W  number of instructions retired

## Operation
- **Capture.** On a clock edge with in_valid && in_ready && !flush, all inputs are registered into the held entry and wb_valid is set. Otherwise, if the entry retires or flush is asserted, wb_valid is cleared.
- **Retire.** The entry retires in a cycle where wb_valid && !stall holds.
- **Result select.** The result is chosen combinationally from the held entry by res_sel.
- **Loads (MEM source).**
  - Extract the lane at byte_off, scaled by ld_size.
  - Half and word loads ignore the low offset bits that are below their alignment.
  - Sign-extend or zero-extend to DATA_W according to ld_unsigned.
- **Misalignment.** err_misalign is asserted when the load offset is not aligned to its size: a half at an odd offset, or a word at an offset not divisible by 4.
- **Write enable.** rf_we = wb_valid && regwrite && (dest_addr != 0) && !stall.
  - Writes to register 0 are suppressed.
  - The entry still retires and still counts.
- **Retire counter.** retire_cnt increments by 1 on every retire, whether or not the instruction writes. It wraps modulo 2^CNT_W.
- **Forwarding.**
  - fwd_valid = wb_valid && regwrite && dest_addr != 0. It is independent of stall, so data is forwarded while the write is held.
  - fwd_data equals rf_wdata.
- **Flush.** flush has priority over both capture and retire. An entry that is flushed while stalled is never written and does not count.

## Timing
- Latency is 1 cycle: an input captured at edge N produces rf_we during cycle N+1, provided stall is low.
- rf_we is asserted for exactly one cycle per writing instruction. With back-to-back in_valid, one write per cycle is sustained.
- Under stall, rf_we = 0 and the held entry and all outputs stay stable. in_ready = 0 while the entry is valid.
- Simultaneous retire and capture in the same edge: the new entry replaces the old one with no bubble.
- Reset values: wb_valid = 0, retire_cnt = 0, and all outputs are 0 (in_ready = 1). Reset overrides flush, stall and capture.
- Reset asserted mid-operation: the held entry is dropped, no write is issued, and retire_cnt is cleared.

## Configuration
- WB_LOAD_EXT_EN defined: the byte/half/word extraction and extension described above is built, along with err_misalign.
- WB_LOAD_EXT_EN undefined:
  - mem_data is passed through unmodified.
  - byte_off, ld_size and ld_unsigned are ignored.
  - err_misalign is tied to 0.

## Test plan
- **Reset then single write:** rst for 2 cycles, then capture regwrite=1, res_sel=00, alu_result=0x0000_1234, dest_addr=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; retire_cnt=1; rf_we=0 the following cycle.
- **Sign-extended byte load:** mem_data=0x80FF_7F01, byte_off=3, ld_size=00, ld_unsigned=0 -> rf_wdata=0xFFFF_FF80. The same load with ld_unsigned=1 -> 0x0000_0080.
- **Misaligned half load:** ld_size=01, byte_off=1 -> err_misalign=1, and data is taken from the half at offset 0.
- **Stall hold:** capture dest_addr=7, then stall=1 for 3 cycles -> rf_we=0, in_ready=0, fwd_valid=1, fwd_addr=7. When stall falls -> one rf_we pulse and retire_cnt advances by 1.
- **Register 0 write and flush under stall:**
  - A write to dest_addr=0 -> rf_we never asserts and retire_cnt still increments.
  - flush during a stalled entry -> no write and the count is unchanged.
- **Back-to-back with counter wrap:** with CNT_W=4, 17 consecutive valid instructions -> 17 single-cycle rf_we pulses and retire_cnt=1.

Source files
------------

// File: rtl/wb_writeback_unit.sv
// MEM/WB pipeline register: selects the result, extends sub-word loads and writes the register file.
// Optional macro WB_LOAD_EXT_EN builds sub-word load extraction and err_misalign.
module wb_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OFF_W  = $clog2(DATA_W/8),
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              regwrite,
  input  logic [1:0]        res_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] link_pc,
  input  logic [DATA_W-1:0] imm_value,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              err_misalign,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic              wb_valid;
  logic              h_regwrite;
  logic [1:0]        h_sel;
  logic [DATA_W-1:0] h_alu, h_mem, h_link, h_imm;
  logic [ADDR_W-1:0] h_dest;
  logic [DATA_W-1:0] mem_ext;
  logic [DATA_W-1:0] result;
  logic              capture, retire;

  assign in_ready = !stall || !wb_valid;
  assign capture  = in_valid && in_ready;
  assign retire   = wb_valid && !stall;

  // flush outranks both capture and retire; a flushed entry never counts
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      retire_cnt <= '0;
      h_regwrite <= 1'b0;
      h_sel      <= '0;
      h_alu      <= '0;
      h_mem      <= '0;
      h_link     <= '0;
      h_imm      <= '0;
      h_dest     <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else begin
      if (retire)
        retire_cnt <= retire_cnt + CNT_W'(1);
      if (capture) begin
        wb_valid   <= 1'b1;
        h_regwrite <= regwrite;
        h_sel      <= res_sel;
        h_alu      <= alu_result;
        h_mem      <= mem_data;
        h_link     <= link_pc;
        h_imm      <= imm_value;
        h_dest     <= dest_addr;
      end else if (retire) begin
        wb_valid <= 1'b0;
      end
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [OFF_W-1:0] h_off, off_h, off_w;
  logic [1:0]       h_size;
  logic             h_uns;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      lane_w;
  logic             misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_off  <= '0;
      h_size <= '0;
      h_uns  <= 1'b0;
    end else if (!flush && capture) begin
      h_off  <= byte_off;
      h_size <= ld_size;
      h_uns  <= ld_unsigned;
    end
  end

  // half and word lanes drop the offset bits below their alignment
  assign off_h  = h_off & ~OFF_W'(1);
  assign off_w  = h_off & ~OFF_W'(3);
  assign lane_b = 8'(h_mem >> {h_off, 3'b000});
  assign lane_h = 16'(h_mem >> {off_h, 3'b000});
  assign lane_w = 32'(h_mem >> {off_w, 3'b000});

  always_comb begin
    mem_ext = h_mem;
    case (h_size)
      2'b00:   mem_ext = h_uns ? DATA_W'(lane_b) : DATA_W'($signed(lane_b));
      2'b01:   mem_ext = h_uns ? DATA_W'(lane_h) : DATA_W'($signed(lane_h));
      2'b10:   mem_ext = h_uns ? DATA_W'(lane_w) : DATA_W'($signed(lane_w));
      default: mem_ext = h_mem;
    endcase
  end

  assign misalign     = (h_size == 2'b01 && h_off[0]) ||
                        (h_size == 2'b10 && h_off[1:0] != 2'b00);
  assign err_misalign = wb_valid && (h_sel == 2'b01) && misalign;
`else
  logic ld_unused;
  assign ld_unused    = ^{byte_off, ld_size, ld_unsigned};
  assign mem_ext      = h_mem;
  assign err_misalign = 1'b0;
`endif

  always_comb begin
    result = h_alu;
    case (h_sel)
      2'b00:   result = h_alu;
      2'b01:   result = mem_ext;
      2'b10:   result = h_link;
      default: result = h_imm;
    endcase
  end

  assign fwd_valid = wb_valid && h_regwrite && (h_dest != '0);
  assign fwd_addr  = h_dest;
  assign fwd_data  = result;
  assign rf_we     = fwd_valid && !stall;
  assign rf_waddr  = h_dest;
  assign rf_wdata  = result;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Randomized self-checking bench for wb_writeback_unit against a transaction-level model.
// Follows the WB_LOAD_EXT_EN build setting of the design.
module tb_wb_writeback_unit;

`ifdef WB_LOAD_EXT_EN
  localparam bit LOAD_EXT = 1'b1;
`else
  localparam bit LOAD_EXT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, stall, flush, regwrite;
  logic [1:0]  res_sel;
  logic [31:0] alu_result, mem_data, link_pc, imm_value;
  logic [1:0]  byte_off, ld_size;
  logic        ld_unsigned;
  logic [4:0]  dest_addr;
  logic        rf_we, fwd_valid, err_misalign;
  logic [4:0]  rf_waddr, fwd_addr;
  logic [31:0] rf_wdata, fwd_data;
  logic [3:0]  retire_cnt;

  wb_writeback_unit #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .regwrite(regwrite), .res_sel(res_sel),
    .alu_result(alu_result), .mem_data(mem_data), .link_pc(link_pc),
    .imm_value(imm_value), .byte_off(byte_off), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .dest_addr(dest_addr), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .err_misalign(err_misalign),
    .retire_cnt(retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rw;
    bit [1:0]    sel;
    bit [31:0]   alu, mem, link, imm;
    bit [1:0]    off, size;
    bit          uns;
    bit [4:0]    dest;
  } entry_t;

  entry_t      m;
  bit          mv;
  int unsigned mcnt;
  int          n_checks = 0;
  int          n_errors = 0;
  int          we_pulses = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_result(entry_t e);
    int unsigned v;
    case (e.sel)
      2'd0: v = e.alu;
      2'd2: v = e.link;
      2'd3: v = e.imm;
      default: begin
        v = e.mem;
`ifdef WB_LOAD_EXT_EN
        if (e.size == 2'd0) begin
          v = (e.mem >> (8 * e.off)) & 32'hFF;
          if (!e.uns && v >= 128) v = v - 256;
        end else if (e.size == 2'd1) begin
          int unsigned base;
          base = e.off - (e.off % 2);
          v = (e.mem >> (8 * base)) & 32'hFFFF;
          if (!e.uns && v >= 32768) v = v - 65536;
        end
`endif
      end
    endcase
    return v;
  endfunction

  task automatic set_idle();
    in_valid = 0; stall = 0; flush = 0; regwrite = 0; res_sel = 0;
    alu_result = 0; mem_data = 0; link_pc = 0; imm_value = 0;
    byte_off = 0; ld_size = 0; ld_unsigned = 0; dest_addr = 0;
  endtask

  task automatic set_instr(input bit rw, input bit [1:0] sel, input bit [31:0] val, input bit [4:0] dest);
    in_valid = 1; regwrite = rw; res_sel = sel; dest_addr = dest;
    alu_result = val; mem_data = val; link_pc = val; imm_value = val;
  endtask

  // Inputs are applied just after a rising edge; outputs are compared mid-cycle.
  task automatic tick();
    logic [31:0] res;
    bit exp_fv, exp_we, exp_ready, exp_err, retire;
    #3;
    res       = model_result(m);
    exp_fv    = mv && m.rw && (m.dest != 0);
    exp_we    = exp_fv && !stall;
    exp_ready = !stall || !mv;
    exp_err   = LOAD_EXT && mv && (m.sel == 2'd1) &&
                ((m.size == 2'd1 && (m.off % 2) != 0) || (m.size == 2'd2 && (m.off % 4) != 0));
    check("in_ready",     64'(in_ready),     64'(exp_ready));
    check("rf_we",        64'(rf_we),        64'(exp_we));
    check("rf_waddr",     64'(rf_waddr),     64'(m.dest));
    check("rf_wdata",     64'(rf_wdata),     64'(res));
    check("fwd_valid",    64'(fwd_valid),    64'(exp_fv));
    check("fwd_addr",     64'(fwd_addr),     64'(m.dest));
    check("fwd_data",     64'(fwd_data),     64'(res));
    check("err_misalign", 64'(err_misalign), 64'(exp_err));
    check("retire_cnt",   64'(retire_cnt),   64'(mcnt));
    if (rf_we === 1'b1) we_pulses++;
    retire = mv && !stall;
    if (rst) begin
      mv = 0; mcnt = 0; m = '{default: 0};
    end else if (flush) begin
      mv = 0;
    end else begin
      if (retire) mcnt = (mcnt + 1) % 16;
      if (in_valid && exp_ready) begin
        m.rw = regwrite; m.sel = res_sel; m.alu = alu_result; m.mem = mem_data;
        m.link = link_pc; m.imm = imm_value; m.off = byte_off; m.size = ld_size;
        m.uns = ld_unsigned; m.dest = dest_addr;
        mv = 1;
      end else if (retire) begin
        mv = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start_pulses;
    set_idle();
    rst = 1;
    mv = 0; mcnt = 0; m = '{default: 0};
    @(posedge clk);
    #1;
    tick();
    rst = 0;

    // single ALU write
    set_instr(1, 2'b00, 32'h0000_1234, 5'd5);
    tick();
    set_idle();
    check("single_we", 64'(rf_we), 64'(1));
    check("single_wdata", 64'(rf_wdata), 64'h1234);
    tick();
    check("single_cnt", 64'(retire_cnt), 64'(1));
    tick();

    // sign- and zero-extended byte loads
    set_instr(1, 2'b01, 32'h80FF_7F01, 5'd3);
    byte_off = 2'd3; ld_size = 2'b00; ld_unsigned = 0;
    tick();
    set_idle();
    check("byte_sext", 64'(rf_wdata), LOAD_EXT ? 64'hFFFF_FF80 : 64'h80FF_7F01);
    set_instr(1, 2'b01, 32'h80FF_7F01, 5'd3);
    byte_off = 2'd3; ld_size = 2'b00; ld_unsigned = 1;
    tick();
    set_idle();
    check("byte_zext", 64'(rf_wdata), LOAD_EXT ? 64'h0000_0080 : 64'h80FF_7F01);

    // misaligned half load uses the half at offset 0
    set_instr(1, 2'b01, 32'h1234_8001, 5'd4);
    byte_off = 2'd1; ld_size = 2'b01; ld_unsigned = 0;
    tick();
    set_idle();
    check("half_misalign", 64'(err_misalign), 64'(LOAD_EXT));
    check("half_data", 64'(rf_wdata), LOAD_EXT ? 64'hFFFF_8001 : 64'h1234_8001);
    tick();

    // stall hold
    set_instr(1, 2'b11, 32'hCAFE_0007, 5'd7);
    tick();
    set_idle();
    stall = 1;
    repeat (3) tick();
    start_pulses = we_pulses;
    stall = 0;
    tick();
    tick();
    check("stall_release_pulses", 64'(we_pulses - start_pulses), 64'(1));

    // register 0 write, then flush under stall
    set_instr(1, 2'b10, 32'h0000_0400, 5'd0);
    tick();
    set_idle();
    tick();
    set_instr(1, 2'b00, 32'h0000_0055, 5'd9);
    tick();
    set_idle();
    stall = 1;
    tick();
    flush = 1;
    tick();
    set_idle();
    tick();

    // reset while an entry is held
    set_instr(1, 2'b00, 32'h0000_0066, 5'd10);
    tick();
    set_idle();
    stall = 1;
    rst = 1;
    tick();
    rst = 0;
    set_idle();
    tick();

    // 17 back-to-back writes from a clean count wrap a 4-bit counter to 1
    start_pulses = we_pulses;
    for (int i = 0; i < 17; i++) begin
      set_instr(1, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(1, 31)));
      tick();
    end
    set_idle();
    tick();
    check("burst_pulses", 64'(we_pulses - start_pulses), 64'(17));
    check("burst_cnt", 64'(retire_cnt), 64'(1));

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      regwrite    = ($urandom_range(0, 7) != 0);
      res_sel     = 2'($urandom_range(0, 3));
      alu_result  = $urandom;
      mem_data    = $urandom;
      link_pc     = $urandom;
      imm_value   = $urandom;
      byte_off    = 2'($urandom_range(0, 3));
      ld_size     = 2'($urandom_range(0, 3));
      ld_unsigned = 1'($urandom_range(0, 1));
      dest_addr   = 5'($urandom_range(0, 31));
      tick();
    end
    rst = 0;
    set_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
